// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // Word-aligned and inside the DEPTH-word window.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < ADDR_W'(depth * 4));
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin against the last winner, or fixed port-0 priority.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_i,
  output logic [1:0] grant_o
);

  // A lone requester always wins; a tie goes to port 0 unless it won last (round-robin).
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (fixed_i || last_i) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch (port 0) and data (port 1) accesses onto one
// single-port word memory, rejecting misaligned or out-of-range addresses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  state_e            state_q;
  logic              last_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic [1:0]        grant;
  logic              access_ok;
  logic              in_access;
  logic              err_d;
  logic [DATA_W-1:0] rdata_d;

  rr_arbiter2 u_arb (
    .req_i   ({req1_i, req0_i}),
    .last_i  (last_q),
    .fixed_i (FIXED_PRIO),
    .grant_o (grant)
  );

  assign accept = !rst_i && (state_q == ST_IDLE || state_q == ST_RESP) && (req0_i || req1_i);
  assign gnt0_o = accept && grant[0];
  assign gnt1_o = accept && grant[1];

  // Rejected accesses keep the memory bus fully idle.
  assign access_ok = addr_ok(addr_q, DEPTH);
  assign in_access = (state_q == ST_ACCESS) && !rst_i && access_ok;
  assign mem_a_o   = in_access ? addr_q : '0;
  assign mem_we_o  = in_access && we_q;
  assign mem_wd_o  = in_access ? wd_q : '0;

  assign err_d   = !access_ok;
  assign rdata_d = (access_ok && !we_q) ? mem_rd_i : '0;

  assign rvalid0_o = (state_q == ST_RESP) && (port_q == PORT_IF);
  assign rvalid1_o = (state_q == ST_RESP) && (port_q == PORT_D);
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_D;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            port_q  <= grant[1];
            last_q  <= grant[1];
            we_q    <= grant[1] && we1_i;
            addr_q  <= grant[1] ? addr1_i : addr0_i;
            wd_q    <= grant[1] ? wd1_i : '0;
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          err_q   <= err_d;
          rdata_q <= rdata_d;
          state_q <= ST_RESP;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven and random checks of mem_arbiter against a memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        req0, req1, we1;
  logic [31:0] addr0, addr1, wd1;
  logic        gnt0, gnt1, rv0, rv1, err;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic        f_gnt0, f_gnt1, f_rv0, f_rv1, f_err, f_we;
  logic [31:0] f_rdata, f_mem_a, f_wd;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(2048), .FIXED_PRIO(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(gnt0), .rvalid0_o(rv0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wd1_i(wd1),
    .gnt1_o(gnt1), .rvalid1_o(rv1), .err_o(err), .rdata_o(rdata),
    .mem_a_o(mem_a), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  mem_arbiter #(.DEPTH(2048), .FIXED_PRIO(1'b1)) u_fix (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .gnt0_o(f_gnt0), .rvalid0_o(f_rv0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wd1_i(wd1),
    .gnt1_o(f_gnt1), .rvalid1_o(f_rv1), .err_o(f_err), .rdata_o(f_rdata),
    .mem_a_o(f_mem_a), .mem_we_o(f_we), .mem_wd_o(f_wd), .mem_rd_i(32'h0)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)    return 32'hDEADBEEF;
    if (i == 16)   return 32'h11111111;
    if (i == 2047) return 32'hCAFEF00D;
    return 32'h10000000 + 32'(i);
  endfunction

  // Memory model: combinational read, write on posedge.
  logic [31:0] tb_mem [0:2047];
  logic [31:0] ref_mem [0:2047];
  assign mem_rd = tb_mem[mem_a[12:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) tb_mem[i] <= init_word(i);
    end else if (mem_we) begin
      tb_mem[mem_a[12:2]] <= mem_wd;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic ok_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h2000);
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [10];

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t exp_q [$];

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    if (r == 1) return 32'h2000 + 32'(4 * $urandom_range(0, 3));
    if (r == 2) return 32'h1FFC;
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic pop_rvalid(input int cyc);
    exp_t e;
    if (rv0 || rv1) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious_rvalid", {30'd0, rv1, rv0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_rvalid_port", {30'd0, rv1, rv0}, e.port ? 32'd2 : 32'd1);
        check("rnd_err", {31'd0, err}, {31'd0, e.err});
        check("rnd_rdata", rdata, e.rdata);
        check("rnd_latency", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  initial begin
    logic [1:0] g;
    logic       p0, p1, pwe1;
    logic [31:0] pa0, pa1, pwd1;
    exp_t e;

    vecs[0] = '{1'b0, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20,   32'h12345678, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20,   32'h0,        1'b0, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 32'h22,   32'h77777777, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h20,   32'h0,        1'b0, 32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 32'h1FFC, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b1, 32'h1FFC, 32'hA5A5A5A5, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h1FFC, 32'h0,        1'b0, 32'hA5A5A5A5};
    vecs[9] = '{1'b0, 1'b0, 32'h11,   32'h0,        1'b1, 32'h0};
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);

    rst = 1'b1; preload = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wd1 = '0;

    // Reset: outputs idle, grants suppressed even with requests present.
    @(negedge clk);
    preload = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40;
    #1;
    check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check("rst_rvalid", {30'd0, rv1, rv0}, 32'd0);
    check("rst_err_rdata", {31'd0, err} | rdata, 32'd0);
    check("rst_mem_bus", {31'd0, mem_we} | mem_a | mem_wd, 32'd0);
    check("rst_fix_outs", {25'd0, f_gnt0, f_gnt1, f_rv0, f_rv1, f_err, f_we, 1'b0}
          | f_rdata | f_mem_a | f_wd, 32'd0);
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; addr1 = '0;

    // Both held: accept every 2 cycles; round-robin alternates, fixed sticks to port 0.
    @(negedge clk);
    g = 2'b00;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0; addr1 = 32'h4; we1 = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1;
      if (c % 2 == 0) begin
        check("rr_gnt", {30'd0, gnt1, gnt0}, ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
        check("fix_gnt", {30'd0, f_gnt1, f_gnt0}, 32'd1);
        check("rr_rvalid", {30'd0, rv1, rv0}, {30'd0, g});
        g = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
      end else begin
        check("rr_gap", {28'd0, gnt1, gnt0, f_gnt1, f_gnt0}, 32'd0);
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("rr_last_rvalid", {30'd0, rv1, rv0}, 32'd2);
    check("rr_last_rdata", rdata, 32'h10000001);

    // Single transactions with hand-computed results.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0 = !vecs[i].port; req1 = vecs[i].port;
      addr0 = vecs[i].addr; addr1 = vecs[i].addr; we1 = vecs[i].we; wd1 = vecs[i].wd;
      #1;
      check($sformatf("v%0d_gnt", i), {30'd0, gnt1, gnt0}, vecs[i].port ? 32'd2 : 32'd1);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0; addr0 = 32'hFFFF_FFF0; addr1 = 32'hFFFF_FFF0; wd1 = '0;
      #1;
      check($sformatf("v%0d_mem_a", i), mem_a, vecs[i].exp_err ? 32'h0 : vecs[i].addr);
      check($sformatf("v%0d_mem_we", i), {31'd0, mem_we},
            {31'd0, vecs[i].we && !vecs[i].exp_err});
      check($sformatf("v%0d_mem_wd", i), mem_wd,
            (vecs[i].we && !vecs[i].exp_err) ? vecs[i].wd : 32'h0);
      check($sformatf("v%0d_no_rvalid", i), {30'd0, rv1, rv0}, 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_rvalid", i), {30'd0, rv1, rv0}, vecs[i].port ? 32'd2 : 32'd1);
      check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_resp_bus_idle", i), {31'd0, mem_we} | mem_a, 32'd0);
      if (vecs[i].we && !vecs[i].exp_err) ref_mem[vecs[i].addr[12:2]] = vecs[i].wd;
    end

    // Reset during the memory cycle of a write aborts it.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wd1 = 32'h00000055;
    #1;
    check("abort_gnt", {30'd0, gnt1, gnt0}, 32'd2);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    check("abort_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_we_forced", {31'd0, mem_we} | mem_a, 32'd0);
    @(negedge clk);
    #1;
    check("abort_no_rvalid", {30'd0, rv1, rv0}, 32'd0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr0 = 32'h0; addr1 = 32'h4;
    #1;
    check("abort_next_gnt_p0", {30'd0, gnt1, gnt0}, 32'd1);
    check("abort_mem_unchanged", tb_mem[16], 32'h11111111);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("abort_access_no_rvalid", {30'd0, rv1, rv0}, 32'd0);
    @(negedge clk);
    #1;
    check("abort_read_rvalid", {30'd0, rv1, rv0}, 32'd1);
    check("abort_read_rdata", rdata, 32'h10000000);

    // Random traffic against the reference memory.
    p0 = 1'b0; p1 = 1'b0; pwe1 = 1'b0; pa0 = '0; pa1 = '0; pwd1 = '0;
    for (int cyc = 0; cyc < 240; cyc++) begin
      @(negedge clk);
      if (cyc < 200) begin
        if (!p0 && $urandom_range(0, 2) != 0) begin
          p0 = 1'b1; pa0 = rand_addr();
        end
        if (!p1 && $urandom_range(0, 2) != 0) begin
          p1 = 1'b1; pa1 = rand_addr(); pwe1 = 1'($urandom_range(0, 1)); pwd1 = $urandom;
        end
      end else begin
        p0 = 1'b0; p1 = 1'b0;
      end
      req0 = p0; addr0 = pa0; req1 = p1; addr1 = pa1; we1 = pwe1; wd1 = pwd1;
      #1;
      pop_rvalid(cyc);
      if (gnt0 && gnt1) check("rnd_gnt_exclusive", {30'd0, gnt1, gnt0}, 32'd1);
      if ((gnt0 && !p0) || (gnt1 && !p1))
        check("rnd_gnt_without_req", {28'd0, p1, p0, gnt1, gnt0}, {28'd0, p1, p0, p1, p0});
      if (gnt0 || gnt1) begin
        e.port  = gnt1;
        e.due   = cyc + 2;
        e.err   = gnt1 ? !ok_addr(pa1) : !ok_addr(pa0);
        if (gnt1 && pwe1) begin
          e.rdata = '0;
          if (!e.err) ref_mem[pa1[12:2]] = pwd1;
        end else begin
          e.rdata = e.err ? 32'h0 : ref_mem[gnt1 ? pa1[12:2] : pa0[12:2]];
        end
        exp_q.push_back(e);
        if (gnt1) p1 = 1'b0;
        else p0 = 1'b0;
      end
    end
    check("rnd_all_responded", 32'(exp_q.size()), 32'd0);
    check("rnd_mem_final_last", tb_mem[2047], ref_mem[2047]);
    check("rnd_mem_final_w8", tb_mem[8], ref_mem[8]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
